// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage bit positions, forward-select codes, MDU state encoding
// and the forwarding-select helper used by the hazard unit.
package pipe_pkg;

  localparam int IF_S  = 4;
  localparam int ID_S  = 3;
  localparam int EX_S  = 2;
  localparam int MEM_S = 1;
  localparam int WB_S  = 0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // The youngest producer (MEM) wins over WB; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit bundle: stage status in, stall/flush/extend and forwarding controls out.
interface hazard_unit_if;

  logic       id_valid;
  logic       ex_valid;
  logic       mem_valid;
  logic       wb_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] ex_rd;
  logic       ex_regwrite;
  logic       ex_is_load;
  logic       ex_is_mdu;
  logic       ex_branch_taken;
  logic [4:0] mem_rd;
  logic [4:0] wb_rd;
  logic       mem_regwrite;
  logic       wb_regwrite;
  logic       imem_wait;
  logic       dmem_wait;
  logic [4:0] stall;
  logic [4:0] flush;
  logic [4:0] extend;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       pc_redirect;
  logic       mdu_busy;

  modport master (
    output id_valid, ex_valid, mem_valid, wb_valid,
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_rs, ex_rt, ex_rd, ex_regwrite, ex_is_load, ex_is_mdu, ex_branch_taken,
    output mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    output imem_wait, dmem_wait,
    input  stall, flush, extend, fwd_a, fwd_b, pc_redirect, mdu_busy
  );

  modport slave (
    input  id_valid, ex_valid, mem_valid, wb_valid,
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_rs, ex_rt, ex_rd, ex_regwrite, ex_is_load, ex_is_mdu, ex_branch_taken,
    input  mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    input  imem_wait, dmem_wait,
    output stall, flush, extend, fwd_a, fwd_b, pc_redirect, mdu_busy
  );

endinterface

// File: rtl/hazard_unit_mdu_tracker.sv
// Tracks a multicycle mul/div occupying EX; mdu_busy holds EX until the op's last cycle.
module mdu_tracker
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_valid,
  input  logic ex_is_mdu,
  input  logic dmem_wait,
  output logic mdu_busy
);

  localparam int             CW       = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'((MDU_LAT > 2) ? (MDU_LAT - 2) : 0);
  localparam logic           MULTI    = (MDU_LAT > 1) ? 1'b1 : 1'b0;

  mdu_state_e    state_r;
  logic [CW-1:0] cnt_r;
  logic          start_s;

  assign start_s = ex_valid & ex_is_mdu & MULTI & ~dmem_wait;

  // MDU state and remaining-cycle counter; a MEM stall freezes both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= MDU_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        MDU_IDLE: begin
          if (start_s) begin
            state_r <= MDU_BUSY;
            cnt_r   <= CNT_LOAD;
          end else begin
            state_r <= MDU_IDLE;
            cnt_r   <= cnt_r;
          end
        end
        MDU_BUSY: begin
          if (dmem_wait) begin
            state_r <= MDU_BUSY;
            cnt_r   <= cnt_r;
          end else if (cnt_r == {CW{1'b0}}) begin
            state_r <= MDU_IDLE;
            cnt_r   <= cnt_r;
          end else begin
            state_r <= MDU_BUSY;
            cnt_r   <= cnt_r - CW'(1);
          end
        end
        default: begin
          state_r <= MDU_IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Busy from the start cycle through the second-to-last cycle of the op.
  always_comb begin
    if (state_r == MDU_BUSY) begin
      mdu_busy = (cnt_r != {CW{1'b0}});
    end else begin
      mdu_busy = start_s;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding controller for the 5-stage pipeline: produces stall/flush/extend
// requests for the bubble controller, branch redirect, and EX operand forwarding selects.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int MDU_LAT     = 4,
  parameter int BOOT_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hz
);

  localparam int            BW        = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES);

  logic [BW-1:0] boot_cnt_r;
  logic          mdu_busy_s;
  logic          load_use_s;
  logic          redirect_s;
  logic [4:0]    req_s;
  logic [4:0]    stall_s;
  logic [4:0]    flush_s;
  logic [4:0]    extend_s;

  // Boot countdown: IF is bubbled until the fetch path has settled after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boot_cnt_r <= BOOT_INIT;
    end else if (boot_cnt_r != {BW{1'b0}}) begin
      boot_cnt_r <= boot_cnt_r - BW'(1);
    end else begin
      boot_cnt_r <= boot_cnt_r;
    end
  end

  mdu_tracker #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (hz.ex_valid),
    .ex_is_mdu (hz.ex_is_mdu),
    .dmem_wait (hz.dmem_wait),
    .mdu_busy  (mdu_busy_s)
  );

  // Stall requests indexed by stage; the oldest (lowest index) request wins, and a taken
  // branch squashes ID/IF instead of holding them.
  always_comb begin
    load_use_s = hz.ex_valid & hz.ex_is_load & (hz.ex_rd != 5'd0) & hz.id_valid &
                 ((hz.id_use_rs & (hz.id_rs == hz.ex_rd)) |
                  (hz.id_use_rt & (hz.id_rt == hz.ex_rd)));
    redirect_s = hz.ex_valid & hz.ex_branch_taken & ~hz.dmem_wait & ~mdu_busy_s;

    req_s        = 5'b00000;
    req_s[WB_S]  = 1'b0;
    req_s[MEM_S] = hz.dmem_wait;
    req_s[EX_S]  = mdu_busy_s;
    req_s[ID_S]  = load_use_s & ~redirect_s;
    req_s[IF_S]  = hz.imem_wait & ~redirect_s;
    stall_s      = req_s & (~req_s + 5'd1);

    flush_s        = 5'b00000;
    flush_s[ID_S]  = redirect_s;

    extend_s       = 5'b00000;
    extend_s[IF_S] = (boot_cnt_r != {BW{1'b0}});
  end

  assign hz.stall       = stall_s;
  assign hz.flush       = flush_s;
  assign hz.extend      = extend_s;
  assign hz.pc_redirect = redirect_s;
  assign hz.mdu_busy    = mdu_busy_s;
  assign hz.fwd_a = fwd_sel(hz.ex_rs, hz.mem_valid & hz.mem_regwrite, hz.mem_rd,
                            hz.wb_valid & hz.wb_regwrite, hz.wb_rd);
  assign hz.fwd_b = fwd_sel(hz.ex_rt, hz.mem_valid & hz.mem_regwrite, hz.mem_rd,
                            hz.wb_valid & hz.wb_regwrite, hz.wb_rd);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a cycle-count reference model.
module tb_hazard_unit;

  localparam int MDU_LAT     = 4;
  localparam int BOOT_CYCLES = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   mdu_left;   // EX cycles the current mul/div still needs, including this one
  int   boot_left;  // bubble cycles IF still has to see

  hazard_unit_if hz ();

  hazard_unit #(
    .MDU_LAT     (MDU_LAT),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.id_valid = 1'b0;  hz.ex_valid = 1'b0;  hz.mem_valid = 1'b0;  hz.wb_valid = 1'b0;
    hz.id_rs = 5'd0;  hz.id_rt = 5'd0;  hz.id_use_rs = 1'b0;  hz.id_use_rt = 1'b0;
    hz.ex_rs = 5'd0;  hz.ex_rt = 5'd0;  hz.ex_rd = 5'd0;
    hz.ex_regwrite = 1'b0;  hz.ex_is_load = 1'b0;  hz.ex_is_mdu = 1'b0;
    hz.ex_branch_taken = 1'b0;
    hz.mem_rd = 5'd0;  hz.wb_rd = 5'd0;  hz.mem_regwrite = 1'b0;  hz.wb_regwrite = 1'b0;
    hz.imem_wait = 1'b0;  hz.dmem_wait = 1'b0;
  endtask

  function automatic logic [4:0] exp_fwd(input logic [4:0] src);
    if (hz.mem_valid && hz.mem_regwrite && hz.mem_rd != 5'd0 && hz.mem_rd == src) return 5'd1;
    if (hz.wb_valid && hz.wb_regwrite && hz.wb_rd != 5'd0 && hz.wb_rd == src) return 5'd2;
    return 5'd0;
  endfunction

  // Compare every output against the model for the inputs currently applied.
  task automatic check_all(input string tag);
    bit mul_start, busy, lu, redir;
    int holder;
    logic [4:0] e_stall;
    mul_start = hz.ex_valid && hz.ex_is_mdu && !hz.dmem_wait && (MDU_LAT > 1);
    busy  = (mdu_left > 1) || (mdu_left == 0 && mul_start);
    lu    = hz.ex_valid && hz.ex_is_load && hz.ex_rd != 5'd0 && hz.id_valid &&
            ((hz.id_use_rs && hz.id_rs == hz.ex_rd) || (hz.id_use_rt && hz.id_rt == hz.ex_rd));
    redir = hz.ex_valid && hz.ex_branch_taken && !hz.dmem_wait && !busy;
    holder = -1;
    if (hz.dmem_wait)          holder = 1;
    else if (busy)             holder = 2;
    else if (!redir && lu)     holder = 3;
    else if (!redir && hz.imem_wait) holder = 4;
    e_stall = (holder < 0) ? 5'd0 : 5'(1 << holder);
    chk({tag, "_stall"}, hz.stall, e_stall);
    chk({tag, "_flush"}, hz.flush, redir ? 5'b01000 : 5'b00000);
    chk({tag, "_extend"}, hz.extend, (boot_left > 0) ? 5'b10000 : 5'b00000);
    chk({tag, "_redirect"}, 5'(hz.pc_redirect), 5'(redir));
    chk({tag, "_mdu_busy"}, 5'(hz.mdu_busy), 5'(busy));
    chk({tag, "_fwd_a"}, 5'(hz.fwd_a), exp_fwd(hz.ex_rs));
    chk({tag, "_fwd_b"}, 5'(hz.fwd_b), exp_fwd(hz.ex_rt));
  endtask

  task automatic tick(input string tag);
    #1;
    check_all(tag);
  endtask

  // Clock edge: advance the model from the inputs held across the edge.
  task automatic adv();
    @(posedge clk);
    if (mdu_left > 0) begin
      if (!hz.dmem_wait) mdu_left--;
    end else if (hz.ex_valid && hz.ex_is_mdu && !hz.dmem_wait && MDU_LAT > 1) begin
      mdu_left = MDU_LAT - 1;
    end
    if (boot_left > 0) boot_left--;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    mdu_left  = 0;
    boot_left = BOOT_CYCLES;
    tick("rst");
    @(posedge clk);
    tick("rst_hold");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear_inputs();
    #12;
    apply_reset();

    // Boot bubbles on IF
    tick("boot0"); chk("boot0_k", hz.extend, 5'b10000); adv();
    tick("boot1"); chk("boot1_k", hz.extend, 5'b10000); adv();
    tick("boot2"); chk("boot2_k", hz.extend, 5'b00000); adv();

    // Load-use on rs, then the same pair with rs not read
    hz.ex_valid = 1'b1; hz.ex_is_load = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_rd = 5'd5;
    hz.id_valid = 1'b1; hz.id_rs = 5'd5; hz.id_use_rs = 1'b1;
    tick("lu"); chk("lu_k", hz.stall, 5'b01000);
    hz.id_use_rs = 1'b0;
    tick("lu_nouse"); chk("lu_nouse_k", hz.stall, 5'b00000); adv();

    // Multicycle op: three stalled cycles, released on the fourth
    clear_inputs();
    hz.ex_valid = 1'b1; hz.ex_is_mdu = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_rd = 5'd8;
    for (int c = 0; c < 4; c++) begin
      tick("mul");
      chk("mul_k", hz.stall, (c < 3) ? 5'b00100 : 5'b00000);
      if (c == 3) hz.ex_valid = 1'b0;
      adv();
    end

    // Same op with a MEM stall on its second cycle: five EX cycles in total
    hz.ex_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      hz.dmem_wait = (c == 1);
      tick("muldw");
      chk("muldw_k", hz.stall, (c == 1) ? 5'b00010 : ((c < 4) ? 5'b00100 : 5'b00000));
      if (c == 4) hz.ex_valid = 1'b0;
      adv();
    end
    clear_inputs();

    // Taken branch beats an IF stall; a MEM stall delays the redirect
    hz.ex_valid = 1'b1; hz.ex_branch_taken = 1'b1; hz.imem_wait = 1'b1;
    tick("br"); chk("br_flush_k", hz.flush, 5'b01000); chk("br_stall_k", hz.stall, 5'b00000);
    hz.imem_wait = 1'b0; hz.dmem_wait = 1'b1;
    tick("brdw"); chk("brdw_flush_k", hz.flush, 5'b00000); chk("brdw_stall_k", hz.stall, 5'b00010);
    adv();
    hz.dmem_wait = 1'b0;
    tick("brgo"); chk("brgo_k", 5'(hz.pc_redirect), 5'd1); adv();
    clear_inputs();

    // Forwarding priority and register 0
    hz.ex_valid = 1'b1; hz.ex_rs = 5'd3; hz.ex_rt = 5'd3;
    hz.mem_valid = 1'b1; hz.mem_regwrite = 1'b1; hz.mem_rd = 5'd3;
    hz.wb_valid = 1'b1; hz.wb_regwrite = 1'b1; hz.wb_rd = 5'd3;
    tick("fwd_both"); chk("fwd_both_k", 5'(hz.fwd_a), 5'd1);
    hz.mem_rd = 5'd0; hz.wb_regwrite = 1'b0;
    tick("fwd_r0"); chk("fwd_r0_k", 5'(hz.fwd_a), 5'd0);
    hz.mem_regwrite = 1'b0; hz.wb_regwrite = 1'b1;
    tick("fwd_wb"); chk("fwd_wb_k", 5'(hz.fwd_a), 5'd2); adv();
    clear_inputs();

    // Reset in the middle of a multicycle op
    hz.ex_valid = 1'b1; hz.ex_is_mdu = 1'b1;
    tick("mulrst"); adv();
    tick("mulrst1");
    apply_reset();
    tick("postrst"); chk("postrst_k", 5'(hz.mdu_busy), 5'd0);
    chk("postrst_stall_k", hz.stall, 5'b00000); adv();

    // Randomized traffic over a small register window to provoke matches
    for (int i = 0; i < 400; i++) begin
      hz.id_valid = 1'($urandom_range(0, 3) != 0);
      hz.ex_valid = 1'($urandom_range(0, 3) != 0);
      hz.mem_valid = 1'($urandom_range(0, 3) != 0);
      hz.wb_valid = 1'($urandom_range(0, 3) != 0);
      hz.id_rs = 5'($urandom_range(0, 3)); hz.id_rt = 5'($urandom_range(0, 3));
      hz.id_use_rs = 1'($urandom_range(0, 1)); hz.id_use_rt = 1'($urandom_range(0, 1));
      hz.ex_rs = 5'($urandom_range(0, 3)); hz.ex_rt = 5'($urandom_range(0, 3));
      hz.ex_rd = 5'($urandom_range(0, 3));
      hz.ex_regwrite = 1'($urandom_range(0, 1));
      hz.ex_is_load = 1'($urandom_range(0, 2) == 0);
      hz.ex_is_mdu = 1'($urandom_range(0, 5) == 0);
      hz.ex_branch_taken = 1'($urandom_range(0, 3) == 0);
      hz.mem_rd = 5'($urandom_range(0, 3)); hz.wb_rd = 5'($urandom_range(0, 3));
      hz.mem_regwrite = 1'($urandom_range(0, 1)); hz.wb_regwrite = 1'($urandom_range(0, 1));
      hz.imem_wait = 1'($urandom_range(0, 3) == 0);
      hz.dmem_wait = 1'($urandom_range(0, 4) == 0);
      tick("rnd");
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
